// File: rtl/lemming_if.sv
// Walker <-> world link: the walker's Moore state and dig command in one direction,
// and terrain sensing plus the registered dig command in the other.
interface lemming_if;
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
    logic dig_req;
    logic ground;
    logic bump_left;
    logic bump_right;
    logic dig;

    modport master (
        output walk_left, walk_right, aaah, digging, dig_req,
        input  ground, bump_left, bump_right, dig
    );
    modport slave (
        input  walk_left, walk_right, aaah, digging, dig_req,
        output ground, bump_left, bump_right, dig
    );
endinterface

// File: rtl/lemming_world.sv
// Closed-loop terrain model for the lemming walker: tracks column, level and a
// destructible ground map, and senses ground/bumps back to the walker.
module lemming_world #(
    parameter int                     COLS         = 16,
    parameter int                     LEVELS       = 4,
    parameter logic [COLS*LEVELS-1:0] INIT_MAP     = '1,
    parameter int                     START_COL    = 4,
    parameter int                     FALL_CYCLES  = 2,
    parameter int                     DIG_CYCLES   = 3,
    parameter int                     SPLAT_LEVELS = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    lemming_if.slave                  wk,
    output logic [$clog2(COLS)-1:0]   pos,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic                      splat,
    output logic                      proto_err
);
    localparam int PW = $clog2(COLS);
    localparam int LW = $clog2(LEVELS);
    localparam int IW = $clog2(COLS*LEVELS);
    localparam int FW = $clog2(FALL_CYCLES+1);
    localparam int DW = $clog2(DIG_CYCLES+1);
    localparam int NW = $clog2(LEVELS+1);

    localparam logic [PW-1:0] LAST_COL  = PW'(COLS-1);
    localparam logic [LW-1:0] FLOOR     = LW'(LEVELS-1);
    localparam logic [FW-1:0] FALL_LAST = FW'(FALL_CYCLES-1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIG_CYCLES-1);
    localparam logic [NW-1:0] SPLAT_MIN = NW'(SPLAT_LEVELS);

    logic [COLS*LEVELS-1:0] map;
    logic [FW-1:0]          fall_tmr;
    logic [DW-1:0]          dig_tmr;
    logic [NW-1:0]          fall_lvls;
    logic                   dig_q;
    logic [IW-1:0]          idx;
    logic                   at_floor;
    logic                   ground;
    logic                   legal;

    // Outputs depend only on registered state and the walker's Moore outputs.
    assign idx      = IW'(level) * IW'(COLS) + IW'(pos);
    assign at_floor = (level == FLOOR);
    assign ground   = at_floor | map[idx];
    assign legal    = $onehot({wk.walk_left, wk.walk_right, wk.aaah, wk.digging});

    assign wk.ground     = ground;
    assign wk.bump_left  = wk.walk_left  & (pos == '0);
    assign wk.bump_right = wk.walk_right & (pos == LAST_COL);
    assign wk.dig        = dig_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos       <= PW'(START_COL);
            level     <= '0;
            map       <= INIT_MAP;
            fall_tmr  <= '0;
            dig_tmr   <= '0;
            fall_lvls <= '0;
            splat     <= 1'b0;
            proto_err <= 1'b0;
            dig_q     <= 1'b0;
        end else begin
            // The dig command passes through even after a fatal landing.
            dig_q <= wk.dig_req;

            if (!splat) begin
                if (!legal) begin
                    proto_err <= 1'b1;
                end else begin
                    if (wk.walk_left && ground && pos != '0)
                        pos <= pos - 1'b1;
                    else if (wk.walk_right && ground && pos != LAST_COL)
                        pos <= pos + 1'b1;

                    if (wk.aaah) begin
                        if (!ground) begin
                            if (fall_tmr == FALL_LAST) begin
                                fall_tmr <= '0;
                                if (level != FLOOR)    level     <= level + 1'b1;
                                if (fall_lvls != '1)   fall_lvls <= fall_lvls + 1'b1;
                            end else begin
                                fall_tmr <= fall_tmr + 1'b1;
                            end
                        end else begin
                            if (fall_lvls >= SPLAT_MIN) splat <= 1'b1;
                            fall_lvls <= '0;
                            fall_tmr  <= '0;
                        end
                    end else begin
                        fall_lvls <= '0;
                        fall_tmr  <= '0;
                    end

                    // The floor cannot be dug: the timer parks at its last value.
                    if (wk.digging && ground) begin
                        if (dig_tmr == DIG_LAST) begin
                            if (!at_floor) begin
                                map[idx] <= 1'b0;
                                dig_tmr  <= '0;
                            end
                        end else begin
                            dig_tmr <= dig_tmr + 1'b1;
                        end
                    end else begin
                        dig_tmr <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: three maps share one walker stimulus; each scenario
// checks the instance whose terrain exercises it.
module tb_lemming_world;
    localparam logic [63:0] MAP_B = ~64'h0000_0000_0000_0004;
    localparam logic [63:0] MAP_C = ~64'h0000_0000_0010_0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn = 1'b0;
    logic wl = 1'b0, wr = 1'b0, aa = 1'b0, dg = 1'b0, dreq = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    lemming_if ia();
    lemming_if ib();
    lemming_if ic();

    assign ia.walk_left = wl; assign ia.walk_right = wr; assign ia.aaah = aa;
    assign ia.digging = dg;   assign ia.dig_req = dreq;
    assign ib.walk_left = wl; assign ib.walk_right = wr; assign ib.aaah = aa;
    assign ib.digging = dg;   assign ib.dig_req = dreq;
    assign ic.walk_left = wl; assign ic.walk_right = wr; assign ic.aaah = aa;
    assign ic.digging = dg;   assign ic.dig_req = dreq;

    logic [3:0] pos_a, pos_b, pos_c;
    logic [1:0] lvl_a, lvl_b, lvl_c;
    logic       splat_a, splat_b, splat_c;
    logic       perr_a, perr_b, perr_c;

    lemming_world dut_a (.clk(clk), .resetn(resetn), .wk(ia), .pos(pos_a),
                         .level(lvl_a), .splat(splat_a), .proto_err(perr_a));
    lemming_world #(.INIT_MAP(MAP_B)) dut_b (.clk(clk), .resetn(resetn), .wk(ib),
                         .pos(pos_b), .level(lvl_b), .splat(splat_b), .proto_err(perr_b));
    lemming_world #(.INIT_MAP(MAP_C)) dut_c (.clk(clk), .resetn(resetn), .wk(ic),
                         .pos(pos_c), .level(lvl_c), .splat(splat_c), .proto_err(perr_c));

    task automatic drive(input logic l, input logic r, input logic a, input logic d);
        wl = l; wr = r; aa = a; dg = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; dreq = 1'b1;
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        checks++; if (pos_a !== 4'd4)     begin errors++; $display("FAIL reset_pos got %0d want 4", pos_a); end
        checks++; if (lvl_a !== 2'd0)     begin errors++; $display("FAIL reset_level got %0d want 0", lvl_a); end
        checks++; if (ia.ground !== 1'b1) begin errors++; $display("FAIL reset_ground_a got %b want 1", ia.ground); end
        checks++; if (splat_a !== 1'b0)   begin errors++; $display("FAIL reset_splat got %b want 0", splat_a); end
        checks++; if (perr_a !== 1'b0)    begin errors++; $display("FAIL reset_proto got %b want 0", perr_a); end
        checks++; if (ia.dig !== 1'b0)    begin errors++; $display("FAIL reset_dig got %b want 0", ia.dig); end
        checks++; if (ic.ground !== 1'b0) begin errors++; $display("FAIL reset_ground_c got %b want 0", ic.ground); end
        dreq = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_wall_bounce();
        int mp, e;
        do_reset();
        mp = 4;
        for (int i = 0; i < 5; i++) begin
            mp = (mp > 0) ? mp - 1 : 0;
            exp_q.push_back(mp);
            drive(1, 0, 0, 0);
            e = exp_q.pop_front();
            checks++; if (pos_a !== 4'(e)) begin errors++; $display("FAIL wall_pos[%0d] got %0d want %0d", i, pos_a, e); end
            checks++; if (ia.bump_left !== (e == 0)) begin errors++; $display("FAIL wall_bump_left[%0d] got %b want %b", i, ia.bump_left, (e == 0)); end
            checks++; if (ia.bump_right !== 1'b0) begin errors++; $display("FAIL wall_bump_right[%0d] got %b want 0", i, ia.bump_right); end
        end
    endtask

    task automatic test_walk_hole();
        int mp, ep, eg;
        do_reset();
        mp = 4;
        for (int i = 0; i < 4; i++) begin
            if (mp != 2 && mp > 0) mp = mp - 1;
            exp_q.push_back(mp);
            exp_q.push_back(mp != 2);
            drive(1, 0, 0, 0);
            ep = exp_q.pop_front();
            eg = exp_q.pop_front();
            checks++; if (pos_b !== 4'(ep)) begin errors++; $display("FAIL hole_pos[%0d] got %0d want %0d", i, pos_b, ep); end
            checks++; if (ib.ground !== 1'(eg)) begin errors++; $display("FAIL hole_ground[%0d] got %b want %0d", i, ib.ground, eg); end
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(i);
            drive(0, 0, 1, 0);
            ep = exp_q.pop_front();
            checks++; if (lvl_b !== 2'(ep)) begin errors++; $display("FAIL hole_level[%0d] got %0d want %0d", i, lvl_b, ep); end
        end
        checks++; if (ib.ground !== 1'b1) begin errors++; $display("FAIL hole_land_ground got %b want 1", ib.ground); end
        drive(0, 0, 1, 0);
        checks++; if (splat_b !== 1'b0) begin errors++; $display("FAIL hole_splat got %b want 0", splat_b); end
        checks++; if (lvl_b !== 2'd1)   begin errors++; $display("FAIL hole_level_land got %0d want 1", lvl_b); end
        drive(0, 1, 0, 0);
        checks++; if (pos_b !== 4'd3)   begin errors++; $display("FAIL hole_walk_on got %0d want 3", pos_b); end
    endtask

    task automatic test_dig_fall();
        int eg;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(i < 2);
            drive(0, 0, 0, 1);
            eg = exp_q.pop_front();
            checks++; if (ia.ground !== 1'(eg)) begin errors++; $display("FAIL dig_ground[%0d] got %b want %0d", i, ia.ground, eg); end
        end
        checks++; if (lvl_a !== 2'd0) begin errors++; $display("FAIL dig_level got %0d want 0", lvl_a); end
        checks++; if (pos_a !== 4'd4) begin errors++; $display("FAIL dig_pos got %0d want 4", pos_a); end
    endtask

    task automatic test_reset_mid_dig();
        int eg;
        do_reset();
        checks++; if (ia.ground !== 1'b1) begin errors++; $display("FAIL middig_map_restored got %b want 1", ia.ground); end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i < 2);
            drive(0, 0, 0, 1);
            eg = exp_q.pop_front();
            checks++; if (ia.ground !== 1'(eg)) begin errors++; $display("FAIL middig_ground[%0d] got %b want %0d", i, ia.ground, eg); end
        end
    endtask

    task automatic test_fatal_fall();
        int el, es;
        logic [5:0] lv_seq;
        lv_seq = 6'b10_01_01;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            el = (i == 0) ? 0 : (i < 3) ? 1 : 2;
            exp_q.push_back(el);
            exp_q.push_back(i == 4);
            drive(0, 0, 1, 0);
            el = exp_q.pop_front();
            es = exp_q.pop_front();
            checks++; if (lvl_c !== 2'(el)) begin errors++; $display("FAIL fatal_level[%0d] got %0d want %0d", i, lvl_c, el); end
            checks++; if (splat_c !== 1'(es)) begin errors++; $display("FAIL fatal_splat[%0d] got %b want %0d", i, splat_c, es); end
        end
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1:    drive(0, 1, 0, 0);
                2:       drive(0, 0, 1, 0);
                3, 4:    drive(0, 0, 0, 1);
                default: drive(1, 0, 0, 0);
            endcase
            checks++; if (pos_c !== 4'd4) begin errors++; $display("FAIL frozen_pos[%0d] got %0d want 4", i, pos_c); end
            checks++; if (lvl_c !== lv_seq[5:4]) begin errors++; $display("FAIL frozen_level[%0d] got %0d want 2", i, lvl_c); end
            checks++; if (splat_c !== 1'b1) begin errors++; $display("FAIL frozen_splat[%0d] got %b want 1", i, splat_c); end
        end
    endtask

    task automatic test_proto();
        int ep;
        do_reset();
        drive(1, 1, 0, 0);
        checks++; if (perr_a !== 1'b1) begin errors++; $display("FAIL proto_set got %b want 1", perr_a); end
        checks++; if (pos_a !== 4'd4)  begin errors++; $display("FAIL proto_pos_hold got %0d want 4", pos_a); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(3 - i);
            drive(1, 0, 0, 0);
            ep = exp_q.pop_front();
            checks++; if (pos_a !== 4'(ep)) begin errors++; $display("FAIL proto_walk[%0d] got %0d want %0d", i, pos_a, ep); end
            checks++; if (perr_a !== 1'b1)  begin errors++; $display("FAIL proto_sticky[%0d] got %b want 1", i, perr_a); end
        end
        drive(0, 0, 0, 0);
        checks++; if (pos_a !== 4'd2) begin errors++; $display("FAIL proto_none_hold got %0d want 2", pos_a); end
        do_reset();
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL proto_clear got %b want 0", perr_a); end
    endtask

    task automatic test_dig_passthrough();
        logic [7:0] pat;
        int e;
        pat = 8'b1011_0010;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dreq = pat[i];
            exp_q.push_back(pat[i]);
            drive(0, 1, 0, 0);
            e = exp_q.pop_front();
            checks++; if (ia.dig !== 1'(e)) begin errors++; $display("FAIL dig_pass[%0d] got %b want %0d", i, ia.dig, e); end
        end
        resetn = 1'b0; dreq = 1'b1;
        drive(0, 1, 0, 0);
        checks++; if (ia.dig !== 1'b0) begin errors++; $display("FAIL dig_in_reset got %b want 0", ia.dig); end
        resetn = 1'b1;
        drive(0, 1, 0, 0);
        checks++; if (ia.dig !== 1'b1) begin errors++; $display("FAIL dig_after_reset got %b want 1", ia.dig); end
        dreq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wall_bounce();
        test_walk_hole();
        test_dig_fall();
        test_reset_mid_dig();
        test_fatal_fall();
        test_proto();
        test_dig_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
